// File: rtl/dmac_sc_bi_windowed.sv
// Bipolar stochastic multiply-accumulate: per-lane XNOR products of LFSR streams,
// mux-added by a bit-reversed counter, with run control and ones/bipolar-sum results.
module dmac_sc_bi_windowed #(
   parameter int                NUM_LANES    = 16,
   parameter int                DATA_W       = 8,
   parameter logic [DATA_W-1:0] LFSR_TAPS    = 8'hB8,
   parameter int                LEN_MAX_LOG2 = 10
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [NUM_LANES*DATA_W-1:0]           i_a,
   input  logic [NUM_LANES*DATA_W-1:0]           i_b,
   input  logic                                  i_load_a,
   input  logic                                  i_load_b,
   input  logic [NUM_LANES*DATA_W-1:0]           i_seed_a,
   input  logic [NUM_LANES*DATA_W-1:0]           i_seed_b,
   input  logic [$clog2(LEN_MAX_LOG2+1)-1:0]     i_len_log2,
   input  logic                                  i_start,
   input  logic                                  i_abort,
   output logic                                  o_busy,
   output logic                                  o_bit,
   output logic                                  o_bit_vld,
   output logic                                  o_done,
   output logic [LEN_MAX_LOG2:0]                 o_ones,
   output logic signed [LEN_MAX_LOG2+1:0]        o_sum
);

   localparam int SEL_W = $clog2(NUM_LANES);
   localparam int CNT_W = LEN_MAX_LOG2 + 1;
   localparam int LL_W  = $clog2(LEN_MAX_LOG2 + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t state, state_nxt;

   logic [DATA_W-1:0] a_reg  [NUM_LANES];
   logic [DATA_W-1:0] b_reg  [NUM_LANES];
   logic [DATA_W-1:0] lfsr_a [NUM_LANES];
   logic [DATA_W-1:0] lfsr_b [NUM_LANES];

   logic [CNT_W-1:0]     cnt, len, ones;
   logic [NUM_LANES-1:0] p_vec;
   logic [SEL_W-1:0]     sel;
   logic                 p_sel, start_ok, run_step, last;

   logic                 bit_p1, vld_p1;
   logic                 done_p2;
   logic [CNT_W-1:0]     ones_p2;
   logic signed [CNT_W:0] sum_p2;

   function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] s);
      return {s[DATA_W-2:0], ^(s & LFSR_TAPS)};
   endfunction

   // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
   function automatic logic [DATA_W-1:0] seed_fix(input logic [DATA_W-1:0] s);
      return (s == '0) ? DATA_W'(1) : s;
   endfunction

   function automatic logic [SEL_W-1:0] bit_rev(input logic [SEL_W-1:0] v);
      logic [SEL_W-1:0] r;
      for (int i = 0; i < SEL_W; i++) r[i] = v[SEL_W-1-i];
      return r;
   endfunction

   function automatic logic [CNT_W-1:0] len_decode(input logic [LL_W-1:0] l);
      if (l > LL_W'(LEN_MAX_LOG2)) return CNT_W'(1) << LEN_MAX_LOG2;
      return CNT_W'(1) << l;
   endfunction

   // 2*ones - len; the intermediate may wrap but the true result always fits.
   function automatic logic signed [CNT_W:0] bipolar(input logic [CNT_W-1:0] ones_v,
                                                    input logic [CNT_W-1:0] len_v);
      return $signed({ones_v, 1'b0}) - $signed({1'b0, len_v});
   endfunction

   assign start_ok = i_start && (state != S_RUN);
   assign run_step = (state == S_RUN) && !i_abort;
   assign last     = (cnt == len - CNT_W'(1));

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (i_start) state_nxt = S_RUN;
         S_RUN:   if (i_abort) state_nxt = S_IDLE;
                  else if (last) state_nxt = S_DONE;
         S_DONE:  state_nxt = i_start ? S_RUN : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Stage p0: lane comparators, XNOR products and bit-reversed select
   always_comb begin
      p_vec = '0;
      for (int i = 0; i < NUM_LANES; i++)
         p_vec[i] = ~((lfsr_a[i] <= a_reg[i]) ^ (lfsr_b[i] <= b_reg[i]));
   end

   assign sel   = bit_rev(cnt[SEL_W-1:0]);
   assign p_sel = p_vec[sel];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         len     <= '0;
         ones    <= '0;
         bit_p1  <= 1'b0;
         vld_p1  <= 1'b0;
         done_p2 <= 1'b0;
         ones_p2 <= '0;
         sum_p2  <= '0;
         for (int i = 0; i < NUM_LANES; i++) begin
            a_reg[i]  <= '0;
            b_reg[i]  <= '0;
            lfsr_a[i] <= DATA_W'(1);
            lfsr_b[i] <= DATA_W'(1);
         end
      end else begin
         state <= state_nxt;
         for (int i = 0; i < NUM_LANES; i++) begin
            if (i_load_a && state != S_RUN) a_reg[i] <= i_a[i*DATA_W +: DATA_W];
            if (i_load_b && state != S_RUN) b_reg[i] <= i_b[i*DATA_W +: DATA_W];
         end
         if (start_ok) begin
            len  <= len_decode(i_len_log2);
            cnt  <= '0;
            ones <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
               lfsr_a[i] <= seed_fix(i_seed_a[i*DATA_W +: DATA_W]);
               lfsr_b[i] <= seed_fix(i_seed_b[i*DATA_W +: DATA_W]);
            end
         end else if (run_step) begin
            cnt  <= cnt + CNT_W'(1);
            ones <= ones + CNT_W'(p_sel);
            for (int i = 0; i < NUM_LANES; i++) begin
               lfsr_a[i] <= lfsr_step(lfsr_a[i]);
               lfsr_b[i] <= lfsr_step(lfsr_b[i]);
            end
         end
         // Stage p1: registered output bit
         vld_p1 <= run_step;
         if (run_step) bit_p1 <= p_sel;
         // Stage p2: results published one cycle after the last bit
         done_p2 <= (state == S_DONE);
         if (state == S_DONE) begin
            ones_p2 <= ones;
            sum_p2  <= bipolar(ones, len);
         end
      end
   end

   assign o_busy    = (state == S_RUN);
   assign o_bit     = bit_p1;
   assign o_bit_vld = vld_p1;
   assign o_done    = done_p2;
   assign o_ones    = ones_p2;
   assign o_sum     = sum_p2;

endmodule
